// File: rtl/fft_8pt_if.sv
// ============================================================================
// Module      : fft_8pt_if
// Description : Frame bus between the 8-point FFT core and its user.
//               master drives the frame and the advance strobe; slave (the
//               core) returns the transformed frame and its valid flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   enable  : pipeline advance strobe            (master -> slave)
//   d       : LEN x {re[15:0], im[15:0]} frame   (master -> slave)
//   dataout : LEN x {re[15:0], im[15:0]} X[k]    (slave  -> master)
//   valid   : dataout holds a complete frame     (slave  -> master)
// ============================================================================
`default_nettype none

interface fft_8pt_if #(
  parameter int LEN = 8
);
  logic                enable;
  logic [LEN*32-1:0]   d;
  logic [LEN*32-1:0]   dataout;
  logic                valid;

  modport master (
    output enable,
    output d,
    input  dataout,
    input  valid
  );

  modport slave (
    input  enable,
    input  d,
    output dataout,
    output valid
  );
endinterface

`default_nettype wire

// File: rtl/fft_8pt.sv
// ============================================================================
// Module      : fft_8pt
// Description : 8-point radix-2 DIT FFT, three registered butterfly stages
//               with a common clock-enable. Each stage halves its result
//               (floor) and saturates to 16 bits, so the output is
//               X[k] = (1/8) * sum x[n] * W8^(nk) with per-stage truncation.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset, priority over enable
//   bus.enable   : pipeline advance; all stages load only when high
//   bus.d        : input frame, word n = d[32n+:32] = {re, im} signed 16-bit
//   bus.dataout  : output frame, word k = X[k], natural order
//   bus.valid    : high once three enabled edges have filled the pipeline
// ============================================================================
`default_nettype none

module fft_8pt #(
  parameter int LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  fft_8pt_if.slave   bus
);

  localparam int FW = LEN * 32;

  // Q1.14 twiddles W^k = exp(-j*2*pi*k/8), k = 0..3
  localparam logic signed [15:0] C_W0_RE = 16'sd16384;
  localparam logic signed [15:0] C_W0_IM = 16'sd0;
  localparam logic signed [15:0] C_W1_RE = 16'sd11585;
  localparam logic signed [15:0] C_W1_IM = -16'sd11585;
  localparam logic signed [15:0] C_W2_RE = 16'sd0;
  localparam logic signed [15:0] C_W2_IM = -16'sd16384;
  localparam logic signed [15:0] C_W3_RE = -16'sd11585;
  localparam logic signed [15:0] C_W3_IM = -16'sd11585;

  localparam logic signed [18:0] C_SAT_MAX = 19'sd32767;
  localparam logic signed [18:0] C_SAT_MIN = -19'sd32768;

  // --------------------------------------------------------------------------
  // Arithmetic helpers
  // --------------------------------------------------------------------------
  function automatic logic signed [15:0] tw_re(input int k);
    logic signed [15:0] r;
    case (k)
      0:       r = C_W0_RE;
      1:       r = C_W1_RE;
      2:       r = C_W2_RE;
      3:       r = C_W3_RE;
      default: r = C_W0_RE;
    endcase
    return r;
  endfunction

  function automatic logic signed [15:0] tw_im(input int k);
    logic signed [15:0] r;
    case (k)
      0:       r = C_W0_IM;
      1:       r = C_W1_IM;
      2:       r = C_W2_IM;
      3:       r = C_W3_IM;
      default: r = C_W0_IM;
    endcase
    return r;
  endfunction

  // Halve (floor) a 19-bit sum/difference, then clamp to signed 16 bits.
  function automatic logic signed [15:0] half_sat(input logic signed [18:0] v);
    logic signed [18:0] sh;
    logic signed [15:0] r;
    sh = v >>> 1;
    if (sh > C_SAT_MAX)
      r = 16'sh7fff;
    else if (sh < C_SAT_MIN)
      r = 16'sh8000;
    else
      r = sh[15:0];
    return r;
  endfunction

  // One radix-2 DIT stage with span h. For every top index i of a pair
  // (i, i+h) the lower input is rotated by W^k, k = (i mod h)*(4/h), and the
  // pair is replaced by (a+t)/2 and (a-t)/2.
  function automatic logic [FW-1:0] fft_stage(input logic [FW-1:0] x,
                                               input int            h);
    logic [FW-1:0]      y;
    logic signed [15:0] ar, ai, br, bi, wr, wi;
    logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [32:0] acc_re, acc_im, sh_re, sh_im;
    logic signed [17:0] t_re, t_im;
    logic signed [18:0] sum_re, sum_im, dif_re, dif_im;
    int                 k;
    y = '0;
    for (int i = 0; i < LEN; i++) begin
      if ((i % (2 * h)) < h) begin
        k  = (i % h) * (4 / h);
        ar = x[32*i+16 +: 16];
        ai = x[32*i    +: 16];
        br = x[32*(i+h)+16 +: 16];
        bi = x[32*(i+h)    +: 16];
        wr = tw_re(k);
        wi = tw_im(k);

        // Full-precision products, 33-bit accumulate, floor shift by 14.
        p_rr   = 32'(br) * 32'(wr);
        p_ii   = 32'(bi) * 32'(wi);
        p_ri   = 32'(br) * 32'(wi);
        p_ir   = 32'(bi) * 32'(wr);
        acc_re = 33'(p_rr) - 33'(p_ii);
        acc_im = 33'(p_ri) + 33'(p_ir);
        sh_re  = acc_re >>> 14;
        sh_im  = acc_im >>> 14;
        // |t| <= 2^16, so 18 bits always hold it without saturation.
        t_re   = sh_re[17:0];
        t_im   = sh_im[17:0];

        sum_re = 19'(ar) + 19'(t_re);
        sum_im = 19'(ai) + 19'(t_im);
        dif_re = 19'(ar) - 19'(t_re);
        dif_im = 19'(ai) - 19'(t_im);

        y[32*i+16     +: 16] = half_sat(sum_re);
        y[32*i        +: 16] = half_sat(sum_im);
        y[32*(i+h)+16 +: 16] = half_sat(dif_re);
        y[32*(i+h)    +: 16] = half_sat(dif_im);
      end
    end
    return y;
  endfunction

  // --------------------------------------------------------------------------
  // Bit-reversed input ordering: stage-1 slot n takes input word rev3(n)
  // --------------------------------------------------------------------------
  logic [FW-1:0] frame_rev;

  for (genvar n = 0; n < LEN; n++) begin : g_rev
    localparam int REV = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
    assign frame_rev[32*n +: 32] = bus.d[32*REV +: 32];
  end

  // --------------------------------------------------------------------------
  // Pipeline: each register stage feeds only the next stage's butterflies
  // --------------------------------------------------------------------------
  logic [FW-1:0] s1_d, s1_q;
  logic [FW-1:0] s2_d, s2_q;
  logic [FW-1:0] s3_d, s3_q;
  logic [1:0]    cnt_d, cnt_q;

  always_comb begin
    s1_d  = fft_stage(frame_rev, 1);
    s2_d  = fft_stage(s1_q, 2);
    s3_d  = fft_stage(s2_q, 4);
    // Fill counter saturates once the pipeline holds a full result.
    cnt_d = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      cnt_q <= 2'd0;
    end else if (bus.enable) begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.dataout = s3_q;
  assign bus.valid   = (cnt_q == 2'd3);

endmodule

`default_nettype wire

// File: tb/tb_fft_8pt.sv
// ============================================================================
// Module      : tb_fft_8pt
// Description : Directed self-checking bench for fft_8pt. Frames and their
//               expected spectra are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_8pt;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_8pt_if #(.LEN(8)) bus ();

  fft_8pt #(.LEN(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [255:0] f_imp, f_dc, f_nyq, f_fs, f_t1, f_t2;
  logic [255:0] x_imp, x_dc, x_nyq, x_fs, x_t1, x_t2;

  function automatic logic [31:0] cw(input int re, input int im);
    logic [31:0] r, i;
    r = re;
    i = im;
    return {r[15:0], i[15:0]};
  endfunction

  function automatic logic [255:0] f8(input logic [31:0] w0, w1, w2, w3,
                                      input logic [31:0] w4, w5, w6, w7);
    return {w7, w6, w5, w4, w3, w2, w1, w0};
  endfunction

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    step();
    rst_n      = 1'b1;
  endtask

  task automatic run_three(input logic [255:0] frame);
    do_reset();
    bus.d      = frame;
    bus.enable = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.enable = 1'b1;
    bus.d      = f_fs;
    step();
    step();
    checks++;
    if (bus.dataout !== 256'd0) begin
      errors++;
      $display("FAIL reset_dataout: got %h expected 0", bus.dataout);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", bus.valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_impulse();
    do_reset();
    bus.d      = f_imp;
    bus.enable = 1'b1;
    step();
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL impulse_valid_e1: got %b expected 0", bus.valid);
    end
    step();
    checks++;
    if (bus.valid !== 1'b0 || bus.dataout !== 256'd0) begin
      errors++;
      $display("FAIL impulse_e2: got valid %b data %h expected valid 0 data 0",
               bus.valid, bus.dataout);
    end
    step();
    checks++;
    if (bus.dataout !== x_imp) begin
      errors++;
      $display("FAIL impulse_data: got %h expected %h", bus.dataout, x_imp);
    end
    checks++;
    if (bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL impulse_valid_e3: got %b expected 1", bus.valid);
    end
  endtask

  task automatic test_dc();
    run_three(f_dc);
    checks++;
    if (bus.dataout !== x_dc) begin
      errors++;
      $display("FAIL dc_data: got %h expected %h", bus.dataout, x_dc);
    end
  endtask

  task automatic test_nyquist();
    run_three(f_nyq);
    checks++;
    if (bus.dataout !== x_nyq) begin
      errors++;
      $display("FAIL nyquist_data: got %h expected %h", bus.dataout, x_nyq);
    end
  endtask

  task automatic test_full_scale();
    run_three(f_fs);
    checks++;
    if (bus.dataout !== x_fs) begin
      errors++;
      $display("FAIL fullscale_data: got %h expected %h", bus.dataout, x_fs);
    end
  endtask

  task automatic test_twiddles();
    run_three(f_t1);
    checks++;
    if (bus.dataout !== x_t1) begin
      errors++;
      $display("FAIL tone1_data: got %h expected %h", bus.dataout, x_t1);
    end
    run_three(f_t2);
    checks++;
    if (bus.dataout !== x_t2) begin
      errors++;
      $display("FAIL tone2_data: got %h expected %h", bus.dataout, x_t2);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.d      = f_imp;
    bus.enable = 1'b1;
    step();
    step();
    bus.enable = 1'b0;
    for (int s = 0; s < 5; s++) begin
      // Changing d while stalled must not reach the pipeline.
      bus.d = f_dc;
      step();
      checks++;
      if (bus.dataout !== 256'd0 || bus.valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid %b data %h expected valid 0 data 0",
                 s, bus.valid, bus.dataout);
      end
    end
    bus.enable = 1'b1;
    step();
    checks++;
    if (bus.dataout !== x_imp || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got valid %b data %h expected valid 1 data %h",
               bus.valid, bus.dataout, x_imp);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.enable = 1'b1;
    bus.d = f_imp; step();
    bus.d = f_dc;  step();
    bus.d = f_t1;  step();
    checks++;
    if (bus.dataout !== x_imp) begin
      errors++;
      $display("FAIL b2b_f0: got %h expected %h", bus.dataout, x_imp);
    end
    bus.d = f_nyq; step();
    checks++;
    if (bus.dataout !== x_dc) begin
      errors++;
      $display("FAIL b2b_f1: got %h expected %h", bus.dataout, x_dc);
    end
    bus.d = f_t2;  step();
    checks++;
    if (bus.dataout !== x_t1) begin
      errors++;
      $display("FAIL b2b_f2: got %h expected %h", bus.dataout, x_t1);
    end
    step();
    checks++;
    if (bus.dataout !== x_nyq) begin
      errors++;
      $display("FAIL b2b_f3: got %h expected %h", bus.dataout, x_nyq);
    end
    step();
    checks++;
    if (bus.dataout !== x_t2 || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_f4: got valid %b data %h expected valid 1 data %h",
               bus.valid, bus.dataout, x_t2);
    end
  endtask

  task automatic test_reset_midstream();
    run_three(f_dc);
    checks++;
    if (bus.dataout !== x_dc || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_fill: got valid %b data %h expected valid 1 data %h",
               bus.valid, bus.dataout, x_dc);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (bus.dataout !== 256'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got valid %b data %h expected valid 0 data 0",
               bus.valid, bus.dataout);
    end
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      step();
      checks++;
      if (bus.dataout !== 256'd0 || bus.valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_refill[%0d]: got valid %b data %h expected valid 0 data 0",
                 s, bus.valid, bus.dataout);
      end
    end
    step();
    checks++;
    if (bus.dataout !== x_dc || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_resume: got valid %b data %h expected valid 1 data %h",
               bus.valid, bus.dataout, x_dc);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.d      = '0;

    f_imp = f8(cw(16384, 0), 0, 0, 0, 0, 0, 0, 0);
    f_dc  = f8(cw(8192, 0), cw(8192, 0), cw(8192, 0), cw(8192, 0),
               cw(8192, 0), cw(8192, 0), cw(8192, 0), cw(8192, 0));
    f_nyq = f8(cw(8000, 0), cw(-8000, 0), cw(8000, 0), cw(-8000, 0),
               cw(8000, 0), cw(-8000, 0), cw(8000, 0), cw(-8000, 0));
    f_fs  = f8(cw(32767, 32767), cw(32767, 32767), cw(32767, 32767), cw(32767, 32767),
               cw(32767, 32767), cw(32767, 32767), cw(32767, 32767), cw(32767, 32767));
    f_t1  = f8(0, cw(16384, 0), 0, 0, 0, 0, 0, 0);
    f_t2  = f8(0, 0, cw(16384, 0), 0, 0, 0, 0, 0);

    x_imp = f8(cw(2048, 0), cw(2048, 0), cw(2048, 0), cw(2048, 0),
               cw(2048, 0), cw(2048, 0), cw(2048, 0), cw(2048, 0));
    x_dc  = f8(cw(8192, 0), 0, 0, 0, 0, 0, 0, 0);
    x_nyq = f8(0, 0, 0, 0, cw(8000, 0), 0, 0, 0);
    x_fs  = f8(cw(32767, 32767), 0, 0, 0, 0, 0, 0, 0);
    // Single sample at n=1: 2048*W^k with floor truncation in the last stage.
    x_t1  = f8(cw(2048, 0), cw(1448, -1449), cw(0, -2048), cw(-1449, -1449),
               cw(-2048, 0), cw(-1448, 1448), cw(0, 2048), cw(1448, 1448));
    // Single sample at n=2: 2048*W^(2k), exercises the stage-2 twiddle.
    x_t2  = f8(cw(2048, 0), cw(0, -2048), cw(-2048, 0), cw(0, 2048),
               cw(2048, 0), cw(0, -2048), cw(-2048, 0), cw(0, 2048));

    test_reset();
    test_impulse();
    test_dc();
    test_nyquist();
    test_full_scale();
    test_twiddles();
    test_stall();
    test_back_to_back();
    test_reset_midstream();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
